// File: rtl/pipe_control_unit.sv
// Registered ID-stage decode/control unit: drives the ID/EX control word one
// cycle after sampling opcode/funct, and sequences multi-cycle mult/div,
// load-use bubbles, branch/jump flushes and a sticky HALT.
module pipe_control_unit #(
  parameter int MUL_LAT  = 4,
  parameter int DIV_LAT  = 8,
  parameter int CNT_W    = 4,
  parameter int FLUSH_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic [3:0] funct_code,
  input  logic [1:0] cmp,
  input  logic       load_use,
  output logic [1:0] byte_access,
  output logic [2:0] alu_op,
  output logic [1:0] alu_src,
  output logic [1:0] write_back,
  output logic       mem_write,
  output logic       mem_read,
  output logic       write_enable_1,
  output logic       write_enable_2,
  output logic       write_data_2,
  output logic       if_flush,
  output logic       pc_src,
  output logic       stall,
  output logic       muldiv_done,
  output logic       halted
);

  typedef struct packed {
    logic [1:0] byte_access;
    logic [2:0] alu_op;
    logic [1:0] alu_src;
    logic [1:0] write_back;
    logic       mem_write;
    logic       mem_read;
    logic       we1;
    logic       we2;
    logic       wd2;
    logic       if_flush;
    logic       pc_src;
  } ctrl_t;

  typedef enum logic [1:0] {RUN, BUSY, HALT} state_t;

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
  localparam logic             FLUSH   = (FLUSH_EN != 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  ctrl_t            ctrl_q;
  ctrl_t            dec;
  ctrl_t            md_fin;
  logic             is_md;
  logic             is_div;
  logic             is_halt;

  // Writeback word for a completed mult/div: result pair goes to both ports.
  always_comb begin
    md_fin            = '0;
    md_fin.write_back = 2'b01;
    md_fin.we1        = 1'b1;
    md_fin.we2        = 1'b1;
  end

  // Pure opcode/funct decode of the instruction sitting in IF/ID.
  always_comb begin
    dec     = '0;
    is_md   = 1'b0;
    is_div  = 1'b0;
    is_halt = 1'b0;
    unique case (opcode)
      4'b0000: begin
        unique case (funct_code)
          4'b0000: begin dec.alu_op = 3'b000; dec.write_back = 2'b01; dec.we1 = 1'b1; end
          4'b0001: begin dec.alu_op = 3'b001; dec.write_back = 2'b01; dec.we1 = 1'b1; end
          4'b1110: begin dec.alu_op = 3'b110; dec.write_back = 2'b01; dec.we1 = 1'b1; end
          4'b1111: begin
            dec.alu_op = 3'b111; dec.write_back = 2'b01;
            dec.we1 = 1'b1; dec.we2 = 1'b1; dec.wd2 = 1'b1;
          end
          4'b0100: begin dec.alu_op = 3'b010; is_md = 1'b1; end
          4'b1000: begin dec.alu_op = 3'b011; is_md = 1'b1; is_div = 1'b1; end
          default: ;
        endcase
      end
      4'b0001: begin dec.alu_op = 3'b100; dec.alu_src = 2'b01; dec.write_back = 2'b01; dec.we1 = 1'b1; end
      4'b0010: begin dec.alu_op = 3'b101; dec.alu_src = 2'b01; dec.write_back = 2'b01; dec.we1 = 1'b1; end
      4'b1000: begin
        dec.byte_access = 2'b01; dec.alu_src = 2'b10; dec.mem_read = 1'b1;
        dec.write_back = 2'b10; dec.we1 = 1'b1;
      end
      4'b1001: begin dec.byte_access = 2'b01; dec.alu_src = 2'b10; dec.mem_write = 1'b1; end
      4'b1010: begin dec.alu_src = 2'b10; dec.mem_read = 1'b1; dec.write_back = 2'b10; dec.we1 = 1'b1; end
      4'b1011: begin dec.alu_src = 2'b10; dec.mem_write = 1'b1; end
      4'b0100, 4'b0101, 4'b0110: begin
        dec.alu_op = 3'b001;
        // blt/bgt/beq are taken on cmp 01/10/11 respectively
        if (cmp != 2'b00 && cmp == opcode[1:0] + 2'b01) begin
          dec.pc_src   = 1'b1;
          dec.if_flush = FLUSH;
        end
      end
      4'b1100: begin dec.pc_src = 1'b1; dec.if_flush = FLUSH; end
      4'b1111: is_halt = 1'b1;
      default: ;
    endcase
  end

  // Sequencer FSM with registered control word, stall, done pulse and halt flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      cnt         <= '0;
      ctrl_q      <= '0;
      stall       <= 1'b0;
      muldiv_done <= 1'b0;
      halted      <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (load_use) begin
            ctrl_q      <= '0;
            stall       <= 1'b1;
            muldiv_done <= 1'b0;
          end else if (is_halt) begin
            ctrl_q      <= '0;
            stall       <= 1'b1;
            muldiv_done <= 1'b0;
            halted      <= 1'b1;
            state       <= HALT;
          end else if (is_md) begin
            if ((is_div ? DIV_LAT : MUL_LAT) > 1) begin
              ctrl_q      <= dec;
              cnt         <= is_div ? DIV_CNT : MUL_CNT;
              stall       <= 1'b1;
              muldiv_done <= 1'b0;
              state       <= BUSY;
            end else begin
              // single-cycle unit: issue and writeback share one word
              ctrl_q      <= dec | md_fin;
              stall       <= 1'b0;
              muldiv_done <= 1'b1;
            end
          end else begin
            ctrl_q      <= dec;
            stall       <= 1'b0;
            muldiv_done <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt == CNT_W'(1)) begin
            ctrl_q      <= md_fin;
            stall       <= 1'b0;
            muldiv_done <= 1'b1;
            cnt         <= '0;
            state       <= RUN;
          end else begin
            ctrl_q      <= '0;
            stall       <= 1'b1;
            muldiv_done <= 1'b0;
            cnt         <= cnt - 1'b1;
          end
        end
        HALT: begin
          ctrl_q      <= '0;
          stall       <= 1'b1;
          muldiv_done <= 1'b0;
          halted      <= 1'b1;
        end
        default: begin
          ctrl_q      <= '0;
          stall       <= 1'b0;
          muldiv_done <= 1'b0;
          state       <= RUN;
        end
      endcase
    end
  end

  assign byte_access    = ctrl_q.byte_access;
  assign alu_op         = ctrl_q.alu_op;
  assign alu_src        = ctrl_q.alu_src;
  assign write_back     = ctrl_q.write_back;
  assign mem_write      = ctrl_q.mem_write;
  assign mem_read       = ctrl_q.mem_read;
  assign write_enable_1 = ctrl_q.we1;
  assign write_enable_2 = ctrl_q.we2;
  assign write_data_2   = ctrl_q.wd2;
  assign if_flush       = ctrl_q.if_flush;
  assign pc_src         = ctrl_q.pc_src;

endmodule

// File: doc/pipe_control_unit.md
Name: pipe_control_unit

Overview:
- Parametrised, registered successor to the combinational 16-bit decode/control unit. Decodes opcode/funct in ID and drives the ID/EX control word one cycle later.
- Adds behaviour the combinational unit lacks:
  - a multi-cycle mult/div sequencer with a pipeline stall;
  - load-use bubble insertion;
  - branch/jump flush;
  - a sticky HALT state.
- Sits between the IF/ID register and the ID/EX register of the CPU pipeline.

Parameters:
- MUL_LAT, 4, EX cycles for signed mult, ≥1.
- DIV_LAT, 8, EX cycles for signed div, ≥1.
- CNT_W, 4, sequencer counter width; must hold max(MUL_LAT, DIV_LAT)-1.
- FLUSH_EN, 1, 1 = assert if_flush on taken branch/jump; 0 = never flush (delay-slot mode).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- opcode  in  4  IF/ID instruction [15:12].
- funct_code  in  4  IF/ID instruction [3:0].
- cmp  in  2  branch comparator result: 00 none, 01 lt, 10 gt, 11 eq.
- load_use  in  1  hazard-unit load-use detect.
- byte_access  out  2  00 word, 01 byte.
- alu_op  out  3  000 add, 001 sub, 010 mult, 011 div, 100 and, 101 or, 110 pass, 111 swap.
- alu_src  out  2  00 reg, 01 zero-extended imm, 10 sign-extended offset.
- write_back  out  2  00 none, 01 ALU, 10 memory.
- mem_write, mem_read  out  1 each.
- write_enable_1, write_enable_2, write_data_2  out  1 each.
- if_flush, pc_src  out  1 each.
- stall  out  1  freezes PC and IF/ID.
- muldiv_done  out  1  one-cycle pulse.
- halted  out  1  sticky.

Behaviour:
- Reset: all outputs 0; FSM = RUN; counter = 0.

Latency and decode:
- All outputs are registered.
- Inputs sampled at edge N appear on the outputs during cycle N+1.

Decode table (outputs not listed are 0):
- R-type, opcode 0000:
  - funct 0000 add: alu_op 000, wb 01, we1.
  - funct 0001 sub: alu_op 001, wb 01, we1.
  - funct 1110 move: alu_op 110, wb 01, we1.
  - funct 1111 swap: alu_op 111, wb 01, we1, we2, write_data_2.
  - funct 0100 mult: alu_op 010, issue only.
  - funct 1000 div: alu_op 011, issue only.
  - any other funct: bubble.
- 0001 andi: alu_op 100, src 01, wb 01, we1.
- 0010 ori: alu_op 101, src 01, wb 01, we1.
- 1000 lb: byte 01, src 10, mem_read, wb 10, we1.
- 1001 sb: byte 01, src 10, mem_write.
- 1010 lw: src 10, mem_read, wb 10, we1.
- 1011 sw: src 10, mem_write.
- 0100 blt, 0101 bgt, 0110 beq: alu_op 001.
  - Taken when cmp is 01, 10, 11 respectively.
  - Taken: pc_src = 1, if_flush = FLUSH_EN.
- 1100 jmp: pc_src = 1, if_flush = FLUSH_EN.
- 1111 halt: bubble; enters HALT.
- Undefined opcodes: bubble.
- "Bubble" means every control output is 0.

FSM states:
- RUN:
  - load_use = 1: register a bubble, stall = 1, no state change. This has priority over decode.
  - mult/div decoded with LAT > 1: load counter = LAT-1, stall = 1, go to BUSY.
  - mult/div decoded with LAT = 1: issue word additionally carries wb 01, we1, we2, muldiv_done; stay in RUN.
- BUSY:
  - Outputs are bubble; stall = 1; counter decrements each cycle.
  - Final cycle (counter 1 → 0): outputs wb 01, we1, we2, muldiv_done = 1; stall = 0; go to RUN.
  - Inputs are ignored while in BUSY.
  - Back-to-back mult/div is legal: the next one issues in the first RUN cycle.
- HALT:
  - Entered on a decoded halt; halted = 1 from the next cycle onward.
  - stall = 1 and all control outputs are 0 permanently.
  - Only rst exits.

Priority and boundary rules:
- Priority: rst > HALT > BUSY > load_use > decode.
- A taken branch together with load_use yields a bubble: the branch is re-decoded once the stall drops.
- pc_src and if_flush are single-cycle pulses.
- rst during BUSY aborts: no muldiv_done and no write enables.

Test Plan:
- Reset then add (0000/0000): next cycle alu_op = 000, write_back = 01, we1 = 1; all others 0.
- Mult with MUL_LAT = 4: cycle 1 alu_op = 010, stall = 1; 2 bubble cycles; cycle 4 muldiv_done = 1, we1 = we2 = 1, stall = 0. Div with DIV_LAT = 8: done pulse lands on the 8th cycle.
- blt with cmp = 01 → pc_src = 1, if_flush = 1 for exactly one cycle. blt with cmp = 00 → both 0. Repeat with FLUSH_EN = 0 → if_flush stays 0.
- lw with load_use = 1 → bubble and stall = 1. Drop load_use → mem_read = 1, alu_src = 10, write_back = 10.
- Halt (1111) → halted = 1 and stall = 1 held for 20 cycles regardless of inputs. rst → all outputs 0, next add decodes normally.
- rst asserted on the 2nd BUSY cycle of a div → no muldiv_done ever; FSM returns to RUN.
